// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised single-clock FIFO.
// Holds count-width sizing, the occupancy flag bundle and parameter legality checks.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic almostfull;
        logic empty;
        logic almostempty;
    } fifo_flags_t;

    // Occupancy runs 0..DEPTH inclusive, hence DEPTH+1 states.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit fifo_params_ok(input int width, input int depth,
                                          input int af_level, input int ae_level);
        return (width >= 1) && (depth >= 2) &&
               (af_level >= 1) && (af_level < depth) &&
               (ae_level > 0) && (ae_level < depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array: DEPTH x WIDTH, synchronous write port, registered read port.
// Latency: read data appears the cycle after re; write visible to a read the next cycle.
// Backpressure: none; the caller gates we/re with full/empty.
module fifo_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO of any depth >= 2 with occupancy count, thresholds and ack/overflow/underflow strobes.
// Latency: write-to-flags 1 cycle, read-to-data_out 1 cycle; strobes are registered one cycle after the request.
// Backpressure: writes rejected while full, reads while empty (flagged by overflow/underflow). FIFO_SVA_EN adds assertions.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              data_out,
    output logic                          data_valid,
    output logic                          wr_ack,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          full,
    output logic                          almostfull,
    output logic                          empty,
    output logic                          almostempty,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count
);

    localparam int  CNT_W     = fifo_cnt_w(DEPTH);
    localparam int  PTR_W     = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam bit  PARAMS_OK = fifo_params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL);

    generate
        if (!PARAMS_OK) begin : g_param_err
            $error("param_sync_fifo: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
        end
    endgenerate

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    fifo_flags_t      flags;
    logic             wr_acc;
    logic             rd_acc;
    logic             ram_we;
    logic             ram_re;

    // Explicit wrap compare so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        flags.full        = (count == CNT_W'(DEPTH));
        flags.empty       = (count == '0);
        flags.almostfull  = (count >= CNT_W'(AF_LEVEL)) && !flags.full;
        flags.almostempty = (count <= CNT_W'(AE_LEVEL)) && !flags.empty;
    end

    assign full        = flags.full;
    assign almostfull  = flags.almostfull;
    assign empty       = flags.empty;
    assign almostempty = flags.almostempty;

    assign wr_acc = wr_en && !flags.full;
    assign rd_acc = rd_en && !flags.empty;
    assign ram_we = rst_n && !flush && wr_acc;
    assign ram_re = rst_n && !flush && rd_acc;

    // Reset and flush clear the same state; only data_out (in the RAM) differs.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wr_ack     <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            wr_ack     <= wr_acc;
            overflow   <= wr_en && flags.full;
            underflow  <= rd_en && flags.empty;
            data_valid <= rd_acc;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

`ifdef FIFO_SVA_EN
    a_wr_ack:   assert property (@(posedge clk) disable iff (!rst_n)
                    (!flush && wr_en && !full) |=> wr_ack);
    a_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                    (!flush && wr_en && full) |=> (overflow && !wr_ack));
    a_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                    (!flush && rd_en && empty) |=> (underflow && !data_valid));
    a_wr_wrap:  assert property (@(posedge clk) disable iff (!rst_n)
                    (!flush && wr_acc && wr_ptr == PTR_W'(DEPTH - 1)) |=> (wr_ptr == '0));
    a_rd_wrap:  assert property (@(posedge clk) disable iff (!rst_n)
                    (!flush && rd_acc && rd_ptr == PTR_W'(DEPTH - 1)) |=> (rd_ptr == '0));
    a_flush_clr: assert property (@(posedge clk) disable iff (!rst_n)
                    flush |=> (wr_ptr == '0 && rd_ptr == '0 && count == '0));
    a_reset_clr: assert property (@(posedge clk)
                    !rst_n |=> (wr_ptr == '0 && rd_ptr == '0 && count == '0));

    always_comb begin
        if (rst_n) begin
            assert (count <= CNT_W'(DEPTH));
            assert (!(full && empty));
            assert (!(almostfull && full) && !(almostempty && empty));
        end
    end

    c_full:     cover property (@(posedge clk) full);
    c_overflow: cover property (@(posedge clk) overflow);
    c_wr_wrap:  cover property (@(posedge clk) wr_acc && wr_ptr == PTR_W'(DEPTH - 1));
    c_flush:    cover property (@(posedge clk) flush && !empty);
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo at DEPTH=8 and DEPTH=6, checked against a queue scoreboard.
module tb_param_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        flush8, wr_en8, rd_en8;
    logic [15:0] din8, dout8;
    logic        dv8, ack8, ovf8, udf8, full8, af8, empty8, ae8;
    logic [3:0]  cnt8;

    logic        flush6, wr_en6, rd_en6;
    logic [15:0] din6, dout6;
    logic        dv6, ack6, ovf6, udf6, full6, af6, empty6, ae6;
    logic [2:0]  cnt6;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] q8[$];
    logic [15:0] q6[$];
    int          mc8, mc6;
    logic [15:0] last8, last6;

    param_sync_fifo #(.WIDTH(16), .DEPTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8), .wr_en(wr_en8), .data_in(din8),
        .rd_en(rd_en8), .data_out(dout8), .data_valid(dv8), .wr_ack(ack8),
        .overflow(ovf8), .underflow(udf8), .full(full8), .almostfull(af8),
        .empty(empty8), .almostempty(ae8), .count(cnt8)
    );

    param_sync_fifo #(.WIDTH(16), .DEPTH(6)) u6 (
        .clk(clk), .rst_n(rst_n), .flush(flush6), .wr_en(wr_en6), .data_in(din6),
        .rd_en(rd_en6), .data_out(dout6), .data_valid(dv6), .wr_ack(ack6),
        .overflow(ovf6), .underflow(udf6), .full(full6), .almostfull(af6),
        .empty(empty6), .almostempty(ae6), .count(cnt6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic [31:0] cnt, input logic f,
                             input logic af, input logic e, input logic ae,
                             input int mc, input int depth, input int af_lvl, input int ae_lvl);
        chk({tag, "_count"},       cnt, mc);
        chk({tag, "_full"},        f,   mc == depth);
        chk({tag, "_almostfull"},  af,  (mc >= af_lvl) && (mc != depth));
        chk({tag, "_empty"},       e,   mc == 0);
        chk({tag, "_almostempty"}, ae,  (mc <= ae_lvl) && (mc != 0));
    endtask

    task automatic cycle8(input logic we, input logic re, input logic [15:0] d);
        logic wa, ra, f, e;
        logic [15:0] exp_out;
        f = (mc8 == 8);
        e = (mc8 == 0);
        wa = we && !f;
        ra = re && !e;
        exp_out = last8;
        if (ra) exp_out = q8.pop_front();
        if (wa) q8.push_back(d);
        mc8 = mc8 + (wa ? 1 : 0) - (ra ? 1 : 0);
        wr_en8 = we; rd_en8 = re; din8 = d;
        tick();
        wr_en8 = 1'b0; rd_en8 = 1'b0;
        last8 = exp_out;
        chk("d8_wr_ack",     ack8,  wa);
        chk("d8_overflow",   ovf8,  we && f);
        chk("d8_underflow",  udf8,  re && e);
        chk("d8_data_valid", dv8,   ra);
        chk("d8_data_out",   dout8, exp_out);
        chk_flags("d8", cnt8, full8, af8, empty8, ae8, mc8, 8, 7, 1);
    endtask

    task automatic cycle6(input logic we, input logic re, input logic [15:0] d);
        logic wa, ra, f, e;
        logic [15:0] exp_out;
        f = (mc6 == 6);
        e = (mc6 == 0);
        wa = we && !f;
        ra = re && !e;
        exp_out = last6;
        if (ra) exp_out = q6.pop_front();
        if (wa) q6.push_back(d);
        mc6 = mc6 + (wa ? 1 : 0) - (ra ? 1 : 0);
        wr_en6 = we; rd_en6 = re; din6 = d;
        tick();
        wr_en6 = 1'b0; rd_en6 = 1'b0;
        last6 = exp_out;
        chk("d6_wr_ack",     ack6,  wa);
        chk("d6_underflow",  udf6,  re && e);
        chk("d6_data_valid", dv6,   ra);
        chk("d6_data_out",   dout6, exp_out);
        chk_flags("d6", cnt6, full6, af6, empty6, ae6, mc6, 6, 5, 1);
    endtask

    // Reset with a write presented on the DEPTH=8 instance; that write must be dropped.
    task automatic do_reset();
        rst_n = 1'b0;
        wr_en8 = 1'b1; din8 = 16'hdead;
        tick();
        mc8 = 0; q8.delete(); last8 = '0;
        mc6 = 0; q6.delete(); last6 = '0;
        chk("rst_wr_ack",     ack8, 1'b0);
        chk("rst_overflow",   ovf8, 1'b0);
        chk("rst_underflow",  udf8, 1'b0);
        chk("rst_data_valid", dv8,  1'b0);
        chk("rst_data_out",   dout8, 16'h0000);
        chk_flags("rst8", cnt8, full8, af8, empty8, ae8, 0, 8, 7, 1);
        chk("rst6_count",     cnt6, 0);
        chk("rst6_data_out",  dout6, 16'h0000);
        rst_n = 1'b1;
        wr_en8 = 1'b0;
    endtask

    task automatic do_flush8();
        flush8 = 1'b1; wr_en8 = 1'b1; rd_en8 = 1'b1; din8 = 16'hbeef;
        tick();
        flush8 = 1'b0; wr_en8 = 1'b0; rd_en8 = 1'b0;
        mc8 = 0; q8.delete();
        chk("flush_wr_ack",     ack8,  1'b0);
        chk("flush_overflow",   ovf8,  1'b0);
        chk("flush_underflow",  udf8,  1'b0);
        chk("flush_data_valid", dv8,   1'b0);
        chk("flush_data_out",   dout8, last8);
        chk_flags("flush8", cnt8, full8, af8, empty8, ae8, 0, 8, 7, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        flush8 = 1'b0; wr_en8 = 1'b0; rd_en8 = 1'b0; din8 = '0;
        flush6 = 1'b0; wr_en6 = 1'b0; rd_en6 = 1'b0; din6 = '0;
        mc8 = 0; mc6 = 0; last8 = '0; last6 = '0;

        do_reset();

        // Fill 0x0001..0x0008, then one write past full.
        for (int i = 1; i <= 8; i++) cycle8(1'b1, 1'b0, 16'(i));
        cycle8(1'b1, 1'b0, 16'h0009);

        // Drain in order, then one read past empty (data_out must hold 0x0008).
        for (int i = 0; i < 8; i++) cycle8(1'b0, 1'b1, 16'h0000);
        cycle8(1'b0, 1'b1, 16'h0000);
        chk("held_after_underflow", dout8, 16'h0008);

        // Simultaneous requests: empty gives write only, full gives read only.
        cycle8(1'b1, 1'b1, 16'h0055);
        for (int i = 0; i < 7; i++) cycle8(1'b1, 1'b0, 16'h0060 + 16'(i));
        cycle8(1'b1, 1'b1, 16'h0077);

        // Bring to count 5, flush, then a read must underflow.
        cycle8(1'b0, 1'b1, 16'h0000);
        cycle8(1'b0, 1'b1, 16'h0000);
        chk("pre_flush_count", cnt8, 5);
        do_flush8();
        cycle8(1'b0, 1'b1, 16'h0000);

        // Reset mid-burst; 0xdead presented during reset must not be stored.
        cycle8(1'b1, 1'b0, 16'h00a1);
        cycle8(1'b1, 1'b0, 16'h00a2);
        cycle8(1'b1, 1'b0, 16'h00a3);
        do_reset();
        cycle8(1'b1, 1'b0, 16'h00b1);
        cycle8(1'b0, 1'b1, 16'h0000);
        cycle8(1'b0, 1'b1, 16'h0000);

        // DEPTH=6: hold at count 3 with both requests for 20 cycles so both pointers wrap.
        for (int i = 0; i < 3; i++) cycle6(1'b1, 1'b0, 16'h0200 + 16'(i));
        for (int i = 0; i < 20; i++) cycle6(1'b1, 1'b1, 16'h0300 + 16'(i));
        for (int i = 0; i < 4; i++) cycle6(1'b0, 1'b1, 16'h0000);
        chk("d6_last_word", dout6, 16'h0313);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
